// File: rtl/frame_bank_scheduler.sv
// frame_bank_scheduler
// Ping-pong scheduler for two single-port frame RAM banks. The ingest stream
// fills the write bank while the framebuffer reads the display bank. The banks
// swap only on SOF, and only once a complete frame is waiting.
//
// Ports:
//   clk, nrst                    clock, asynchronous active-low reset
//   wr_valid_i/wr_ready_o        pixel word handshake
//   wr_data_i, wr_last_i         pixel word and end-of-frame marker
//   flush_i                      abandon partial frame, clear pending/error
//   sof_i                        position sync (swap point)
//   rd_addr_i, rd_data_o         framebuffer read port, 1-cycle latency
//   b0_*/b1_*                    bank address/wdata/we out, rdata in
//   disp_bank_o                  bank currently displayed
//   frame_pending_o              complete frame waiting in the write bank
//   frame_swap_o                 one-cycle pulse: banks swapped
//   swap_skipped_o               one-cycle pulse: SOF without a complete frame
//   err_len_o                    sticky: a frame length was wrong
module frame_bank_scheduler #(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 7,
    parameter int FRAME_WORDS = 128
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_last_i,
    input  logic              flush_i,
    input  logic              sof_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] b0_addr_o,
    output logic [DATA_W-1:0] b0_wdata_o,
    output logic              b0_we_o,
    input  logic [DATA_W-1:0] b0_rdata_i,
    output logic [ADDR_W-1:0] b1_addr_o,
    output logic [DATA_W-1:0] b1_wdata_o,
    output logic              b1_we_o,
    input  logic [DATA_W-1:0] b1_rdata_i,
    output logic              disp_bank_o,
    output logic              frame_pending_o,
    output logic              frame_swap_o,
    output logic              swap_skipped_o,
    output logic              err_len_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    logic              disp_bank_q, disp_bank_d;
    logic              frame_pending_q, frame_pending_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              frame_swap_q, frame_swap_d;
    logic              swap_skipped_q, swap_skipped_d;
    logic              err_len_q, err_len_d;
    logic              rd_sel_q;

    logic accept;
    logic at_end;

    assign wr_ready_o = ~frame_pending_q;
    // Flush suppresses the write itself, not just the bookkeeping.
    assign accept     = wr_valid_i & wr_ready_o & ~flush_i;
    assign at_end     = (wr_addr_q == LAST_ADDR);

    // Bank muxing: display bank is read-only, the other bank takes writes.
    always_comb begin
        b0_wdata_o = wr_data_i;
        b1_wdata_o = wr_data_i;
        if (disp_bank_q) begin
            b1_addr_o = rd_addr_i;
            b1_we_o   = 1'b0;
            b0_addr_o = wr_addr_q;
            b0_we_o   = accept;
        end else begin
            b0_addr_o = rd_addr_i;
            b0_we_o   = 1'b0;
            b1_addr_o = wr_addr_q;
            b1_we_o   = accept;
        end
    end

    // Select follows the bank that was addressed one cycle earlier, so data
    // returned across a swap comes from the bank that was actually read.
    assign rd_data_o = rd_sel_q ? b1_rdata_i : b0_rdata_i;

    always_comb begin
        disp_bank_d     = disp_bank_q;
        frame_pending_d = frame_pending_q;
        wr_addr_d       = wr_addr_q;
        frame_swap_d    = 1'b0;
        swap_skipped_d  = 1'b0;
        err_len_d       = err_len_q;
        if (flush_i) begin
            wr_addr_d       = '0;
            frame_pending_d = 1'b0;
            err_len_d       = 1'b0;
        end else begin
            // A frame completing in the SOF cycle is not yet pending, so SOF
            // is skipped and the swap waits for the next SOF.
            if (sof_i) begin
                if (frame_pending_q) begin
                    disp_bank_d     = ~disp_bank_q;
                    frame_pending_d = 1'b0;
                    frame_swap_d    = 1'b1;
                end else begin
                    swap_skipped_d  = 1'b1;
                end
            end
            // accept implies pending was clear, so this never races the swap.
            if (accept) begin
                if (wr_last_i || at_end) begin
                    wr_addr_d       = '0;
                    frame_pending_d = 1'b1;
                    if (wr_last_i != at_end)
                        err_len_d = 1'b1;
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            disp_bank_q     <= 1'b0;
            frame_pending_q <= 1'b0;
            wr_addr_q       <= '0;
            frame_swap_q    <= 1'b0;
            swap_skipped_q  <= 1'b0;
            err_len_q       <= 1'b0;
            rd_sel_q        <= 1'b0;
        end else begin
            disp_bank_q     <= disp_bank_d;
            frame_pending_q <= frame_pending_d;
            wr_addr_q       <= wr_addr_d;
            frame_swap_q    <= frame_swap_d;
            swap_skipped_q  <= swap_skipped_d;
            err_len_q       <= err_len_d;
            rd_sel_q        <= disp_bank_q;
        end
    end

    assign disp_bank_o     = disp_bank_q;
    assign frame_pending_o = frame_pending_q;
    assign frame_swap_o    = frame_swap_q;
    assign swap_skipped_o  = swap_skipped_q;
    assign err_len_o       = err_len_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler with two behavioural RAM banks
// (registered read, read-before-write).
module tb_frame_bank_scheduler;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 7;

    logic              clk;
    logic              nrst;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              flush;
    logic              sof;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] b0_addr, b1_addr;
    logic [DATA_W-1:0] b0_wdata, b1_wdata;
    logic              b0_we, b1_we;
    logic [DATA_W-1:0] b0_rdata, b1_rdata;
    logic              disp_bank, frame_pending, frame_swap, swap_skipped, err_len;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem0 [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] mem1 [0:(1<<ADDR_W)-1];

    frame_bank_scheduler #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_WORDS(128)
    ) dut (
        .clk(clk), .nrst(nrst),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .wr_data_i(wr_data), .wr_last_i(wr_last),
        .flush_i(flush), .sof_i(sof),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .b0_addr_o(b0_addr), .b0_wdata_o(b0_wdata), .b0_we_o(b0_we), .b0_rdata_i(b0_rdata),
        .b1_addr_o(b1_addr), .b1_wdata_o(b1_wdata), .b1_we_o(b1_we), .b1_rdata_i(b1_rdata),
        .disp_bank_o(disp_bank), .frame_pending_o(frame_pending),
        .frame_swap_o(frame_swap), .swap_skipped_o(swap_skipped), .err_len_o(err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        b0_rdata <= mem0[b0_addr];
        b1_rdata <= mem1[b1_addr];
        if (b0_we) mem0[b0_addr] <= b0_wdata;
        if (b1_we) mem1[b1_addr] <= b1_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; checks follow #1 later.
    task automatic cyc(input bit v, input int d, input bit l, input bit s, input bit f);
        @(negedge clk);
        wr_valid = v;
        wr_data  = DATA_W'(d);
        wr_last  = l;
        sof      = s;
        flush    = f;
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; wr_valid = 0; wr_data = '0; wr_last = 0;
        flush = 0; sof = 0; rd_addr = '0;
        b0_rdata = '0; b1_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_disp", disp_bank, 0);
        chk("rst_pending", frame_pending, 0);
        chk("rst_ready", wr_ready, 1);
        chk("rst_swap", frame_swap, 0);
        chk("rst_skip", swap_skipped, 0);
        chk("rst_err", err_len, 0);
        chk("rst_we", {b0_we, b1_we}, 0);
        nrst = 1'b1;

        // 1: full frame into bank 1, swap, read back
        for (int i = 0; i < 128; i++) begin
            cyc(1, i, i == 127, 0, 0);
            if (i == 0) begin
                chk("s1_b1_we", b1_we, 1);
                chk("s1_b0_we", b0_we, 0);
                chk("s1_b1_addr", b1_addr, 0);
            end
        end
        cyc(0, 0, 0, 0, 0);
        chk("s1_pending", frame_pending, 1);
        chk("s1_ready", wr_ready, 0);
        cyc(0, 0, 0, 1, 0);
        chk("s1_disp_pre", disp_bank, 0);
        cyc(0, 0, 0, 0, 0);
        rd_addr = 7'd5;
        #1;
        chk("s1_swap", frame_swap, 1);
        chk("s1_disp", disp_bank, 1);
        chk("s1_ready_up", wr_ready, 1);
        chk("s1_rdaddr", b1_addr, 5);
        cyc(0, 0, 0, 0, 0);
        chk("s1_rdata", rd_data, 5);
        chk("s1_swap_end", frame_swap, 0);

        // 2: second frame into bank 0, third frame stalls until swap
        for (int i = 0; i < 128; i++) begin
            cyc(1, 1000 + i, i == 127, 0, 0);
            if (i == 0) chk("s2_b0_addr", {b0_we, b0_addr}, {1'b1, 7'd0});
        end
        cyc(1, 2000, 0, 0, 0);
        chk("s2_stall_ready", wr_ready, 0);
        chk("s2_stall_we", {b0_we, b1_we}, 0);
        cyc(1, 2000, 0, 1, 0);
        chk("s2_stall_sof", wr_ready, 0);
        cyc(1, 2000, 0, 0, 0);
        chk("s2_swap", frame_swap, 1);
        chk("s2_disp", disp_bank, 0);
        chk("s2_w0", {b1_we, b1_addr}, {1'b1, 7'd0});
        chk("s2_w0_data", b1_wdata, 2000);

        // 3: SOF mid-frame is skipped, writes continue
        for (int i = 1; i < 60; i++) cyc(1, 2000 + i, 0, 0, 0);
        cyc(1, 2060, 0, 1, 0);
        chk("s3_addr60", b1_addr, 60);
        cyc(1, 2061, 0, 0, 0);
        rd_addr = 7'd7;
        #1;
        chk("s3_skip", swap_skipped, 1);
        chk("s3_disp", disp_bank, 0);
        chk("s3_ready", wr_ready, 1);
        chk("s3_addr61", {b1_we, b1_addr}, {1'b1, 7'd61});
        chk("s3_rdaddr", b0_addr, 7);
        for (int i = 62; i < 128; i++) begin
            cyc(1, 2000 + i, i == 127, 0, 0);
            if (i == 62) begin
                chk("s3_rdata", rd_data, 1007);
                chk("s3_skip_end", swap_skipped, 0);
            end
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s3_swap", frame_swap, 1);
        chk("s3_disp1", disp_bank, 1);
        chk("s3_err", err_len, 0);

        // 4: short frame, then flush together with SOF
        for (int i = 0; i < 10; i++) cyc(1, 3000 + i, i == 9, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s4_err", err_len, 1);
        chk("s4_pending", frame_pending, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s4_swap", frame_swap, 1);
        chk("s4_disp", disp_bank, 0);
        cyc(1, 4000, 0, 1, 1);
        chk("s4_flush_we", {b0_we, b1_we}, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s4_flush_skip", swap_skipped, 0);
        chk("s4_flush_err", err_len, 0);
        chk("s4_flush_disp", disp_bank, 0);

        // 5: overlong frame truncated at 128 words, word 128 stalls
        for (int i = 0; i < 128; i++) begin
            cyc(1, 5000 + i, 0, 0, 0);
            if (i == 0) chk("s5_w0", {b1_we, b1_addr}, {1'b1, 7'd0});
        end
        cyc(1, 5128, 0, 0, 0);
        chk("s5_pending", frame_pending, 1);
        chk("s5_err", err_len, 1);
        chk("s5_stall", {wr_ready, b0_we, b1_we}, 0);
        cyc(1, 5128, 0, 1, 0);
        cyc(1, 5128, 0, 0, 0);
        chk("s5_swap", frame_swap, 1);
        chk("s5_disp", disp_bank, 1);
        chk("s5_w128", {b0_we, b0_addr}, {1'b1, 7'd0});
        chk("s5_w128_data", b0_wdata, 5128);

        // 6: last word together with SOF, then flush mid-frame
        for (int i = 1; i < 128; i++) cyc(1, 5128 + i, i == 127, i == 127, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s6_skip", swap_skipped, 1);
        chk("s6_pending", frame_pending, 1);
        chk("s6_noswap", {frame_swap, disp_bank}, {1'b0, 1'b1});
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s6_swap", frame_swap, 1);
        chk("s6_disp", disp_bank, 0);
        chk("s6_err_sticky", err_len, 1);
        for (int i = 0; i < 5; i++) cyc(1, 6000 + i, 0, 0, 0);
        chk("s6_addr4", b1_addr, 4);
        cyc(1, 6005, 0, 0, 1);
        chk("s6_flush_we", b1_we, 0);
        cyc(1, 6005, 0, 0, 0);
        chk("s6_flush_err", err_len, 0);
        chk("s6_flush_addr", {b1_we, b1_addr}, {1'b1, 7'd0});

        // Reset mid-frame
        cyc(1, 6006, 0, 0, 0);
        nrst = 1'b0;
        #1;
        chk("rst2_addr", b1_addr, 0);
        chk("rst2_disp", disp_bank, 0);
        chk("rst2_ready", wr_ready, 1);
        cyc(0, 0, 0, 0, 0);
        nrst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
